ifm_window_addr_gen: RTL and testbench
======================================

Name: ifm_window_addr_gen

Overview:
- Parametrised successor to the single-mode IFM address generator.
- Walks every output pixel, then every kernel tap, then every channel tile. Emits one IFM word address per beat to the input-buffer read port on a valid/ready handshake.
- Generalised relative to the earlier generator:
  - independent kernel height and width;
  - stride 1-3;
  - zero padding, flagged with pad_flag instead of being fetched;
  - non-multiple-of-PE_LANES channel counts;
  - tap/window markers for the MAC array.

Parameters:
- ADDR_W, 32, address width.
- DIM_W, 8, width of every dimension input and loop counter.
- PE_LANES, 16, channels per tile, i.e. per fetched word.
- WORD_BYTES, 4, byte stride between consecutive tile words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  latch config and begin; honoured only in IDLE
- base_addr  in  ADDR_W  byte address of IFM pixel (0,0), tile 0
- ifm_w  in  DIM_W  IFM width
- ifm_h  in  DIM_W  IFM height
- ifm_c  in  DIM_W  IFM channel count
- ofm_w  in  DIM_W  OFM width
- ofm_h  in  DIM_W  OFM height
- kernel_w  in  4  kernel width
- kernel_h  in  4  kernel height
- stride  in  2  stride, 1-3; 0 is treated as 1
- pad  in  2  zero-padding on every side
- addr_out  out  ADDR_W  fetch address
- addr_valid  out  1  addr_out and flags valid
- addr_ready  in  1  consumer accepts the beat
- pad_flag  out  1  beat lies in padding; consumer substitutes zero
- window_last  out  1  last beat of the current output window
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset values: every output 0, FSM in IDLE, all counters 0.
- Config latching:
  - Inputs are registered when start is accepted.
  - Config changes during RUN have no effect.
  - num_tiles = ceil(ifm_c / PE_LANES).
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On start, latch config and clear counters.
  - If any of ofm_w, ofm_h, kernel_w, kernel_h or ifm_c is 0, go to FIN; no beats are emitted.
  - Otherwise go to RUN. addr_valid is high in the cycle after start is sampled (latency 1).
- RUN:
  - Loop nest, outermost first: oy, ox, ky, kx, t.
  - Counters advance only on a handshake (addr_valid && addr_ready).
  - Beat count = ofm_h * ofm_w * kernel_h * kernel_w * num_tiles.
- Address arithmetic:
  - iy = oy*stride + ky - pad and ix = ox*stride + kx - pad, evaluated signed, DIM_W+3 bits.
  - In range (0 <= iy < ifm_h and 0 <= ix < ifm_w):
    - addr_out = base_addr + ((iy*ifm_w + ix)*num_tiles + t)*WORD_BYTES, truncated to ADDR_W;
    - pad_flag = 0.
  - Otherwise addr_out = 0 and pad_flag = 1. Padded beats still require a handshake.
- window_last = 1 when ky, kx and t are all at their maximum values.
- Back-pressure:
  - While addr_valid && !addr_ready, addr_out, pad_flag and window_last hold stable.
  - addr_valid never drops without a handshake.
- Throughput: one beat per cycle while addr_ready stays high. No bubbles at loop wrap-arounds.
- Final beat: on the handshake where all counters are at max, addr_valid goes low next cycle and the FSM moves to FIN.
- FIN: done = 1 for exactly one cycle, then IDLE. The zero-dimension case follows the same path.
- Start handling:
  - start during RUN or FIN is ignored.
  - A start sampled in the IDLE cycle directly after FIN is accepted.
- Reset mid-operation: immediately returns to IDLE with all outputs 0. There is no pending done.
- busy = (state == RUN).

Test Plan:
1. Basic run, addr_ready tied 1. Config: ifm 4x4, c=16, kernel 3x3, stride 1, pad 0, ofm 2x2, base 0x1000.
   -> 36 beats.
   -> First four addresses: 0x1000, 0x1004, 0x1008, 0x1010.
   -> window_last on beats 9, 18, 27, 36.
   -> Window 2 starts at 0x1004.
   -> done one cycle after beat 36.
2. Padding. Same config with pad=1, ofm 4x4.
   -> 144 beats.
   -> Beat 1: pad_flag=1, addr_out=0.
   -> Beat 5 (ky=1, kx=1): addr 0x1000, pad_flag=0.
3. Multi-tile. c=40 (3 tiles), kernel 1x1, ifm/ofm 2x2, stride 1.
   -> 12 beats; addresses base + 0, 4, 8, 12 ... 44.
   -> window_last every 3rd beat.
4. Stride and back-pressure. ifm 5x5, c=16, kernel 3x3, stride 2, ofm 2x2.
   -> Window 2 starts at base+8.
   -> With addr_ready toggling randomly, the address sequence is identical to the no-stall run and outputs hold stable while stalled.
5. Control edge cases.
   -> start pulsed during RUN: ignored, beat count unchanged.
   -> start with ofm_w=0: no addr_valid, done 2 cycles after start.
   -> rst_n asserted mid-run: all outputs 0 immediately; a following start restarts from beat 1.

Source files
------------

// File: rtl/ifm_window_addr_gen.sv
// IFM window address generator: walks oy, ox, ky, kx, tile and emits one word address per handshake.
// Latency 1 from start to first beat. The beat is held stable while addr_ready is low; one beat per cycle otherwise.
module ifm_window_addr_gen #(
   parameter int ADDR_W     = 32,
   parameter int DIM_W      = 8,
   parameter int PE_LANES   = 16,
   parameter int WORD_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DIM_W-1:0]  ifm_w,
   input  logic [DIM_W-1:0]  ifm_h,
   input  logic [DIM_W-1:0]  ifm_c,
   input  logic [DIM_W-1:0]  ofm_w,
   input  logic [DIM_W-1:0]  ofm_h,
   input  logic [3:0]        kernel_w,
   input  logic [3:0]        kernel_h,
   input  logic [1:0]        stride,
   input  logic [1:0]        pad,
   output logic [ADDR_W-1:0] addr_out,
   output logic              addr_valid,
   input  logic              addr_ready,
   output logic              pad_flag,
   output logic              window_last,
   output logic              busy,
   output logic              done
);

   localparam int SW = DIM_W + 3;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t state, state_nxt;

   // latched configuration
   logic [ADDR_W-1:0] base_r;
   logic [DIM_W-1:0]  ifm_w_r, ifm_h_r;
   logic [DIM_W-1:0]  tiles_r;
   logic [DIM_W-1:0]  ow_max, oh_max, kw_max, kh_max, t_max;
   logic [1:0]        stride_r, pad_r;

   // loop counters
   logic [DIM_W-1:0]  oy, ox, ky, kx, t;

   logic              hs, last_beat, zero_dim;
   logic [DIM_W:0]    tiles_calc;
   logic signed [SW-1:0] iy, ix;
   logic              in_range;
   logic [ADDR_W-1:0] pix_idx, word_idx;

   assign hs        = addr_valid && addr_ready;
   assign zero_dim  = (ofm_w == '0) || (ofm_h == '0) || (kernel_w == '0) ||
                      (kernel_h == '0) || (ifm_c == '0);
   assign tiles_calc = ({1'b0, ifm_c} + (DIM_W+1)'(PE_LANES - 1)) / (DIM_W+1)'(PE_LANES);
   assign last_beat = (oy == oh_max) && (ox == ow_max) && (ky == kh_max) &&
                      (kx == kw_max) && (t == t_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         base_r   <= '0;
         ifm_w_r  <= '0;
         ifm_h_r  <= '0;
         tiles_r  <= '0;
         ow_max   <= '0;
         oh_max   <= '0;
         kw_max   <= '0;
         kh_max   <= '0;
         t_max    <= '0;
         stride_r <= '0;
         pad_r    <= '0;
         oy       <= '0;
         ox       <= '0;
         ky       <= '0;
         kx       <= '0;
         t        <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            base_r   <= base_addr;
            ifm_w_r  <= ifm_w;
            ifm_h_r  <= ifm_h;
            tiles_r  <= DIM_W'(tiles_calc);
            t_max    <= DIM_W'(tiles_calc - (DIM_W+1)'(1));
            ow_max   <= ofm_w - DIM_W'(1);
            oh_max   <= ofm_h - DIM_W'(1);
            kw_max   <= {{(DIM_W-4){1'b0}}, kernel_w} - DIM_W'(1);
            kh_max   <= {{(DIM_W-4){1'b0}}, kernel_h} - DIM_W'(1);
            stride_r <= (stride == 2'd0) ? 2'd1 : stride;
            pad_r    <= pad;
            oy       <= '0;
            ox       <= '0;
            ky       <= '0;
            kx       <= '0;
            t        <= '0;
         end else if (hs) begin
            // tile is innermost; each level wraps into the next outer one
            if (t != t_max) begin
               t <= t + DIM_W'(1);
            end else begin
               t <= '0;
               if (kx != kw_max) begin
                  kx <= kx + DIM_W'(1);
               end else begin
                  kx <= '0;
                  if (ky != kh_max) begin
                     ky <= ky + DIM_W'(1);
                  end else begin
                     ky <= '0;
                     if (ox != ow_max) begin
                        ox <= ox + DIM_W'(1);
                     end else begin
                        ox <= '0;
                        if (oy != oh_max) oy <= oy + DIM_W'(1);
                        else              oy <= '0;
                     end
                  end
               end
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = zero_dim ? FIN : RUN;
         RUN:     if (hs && last_beat) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // input coordinates go negative inside the top/left padding, hence signed
   always_comb begin
      iy = $signed({3'b000, oy}) * $signed({{(SW-2){1'b0}}, stride_r})
         + $signed({3'b000, ky}) - $signed({{(SW-2){1'b0}}, pad_r});
      ix = $signed({3'b000, ox}) * $signed({{(SW-2){1'b0}}, stride_r})
         + $signed({3'b000, kx}) - $signed({{(SW-2){1'b0}}, pad_r});
      in_range = !iy[SW-1] && !ix[SW-1] &&
                 ($unsigned(iy) < {3'b000, ifm_h_r}) &&
                 ($unsigned(ix) < {3'b000, ifm_w_r});
      pix_idx  = ADDR_W'($unsigned(iy)) * ADDR_W'(ifm_w_r) + ADDR_W'($unsigned(ix));
      word_idx = pix_idx * ADDR_W'(tiles_r) + ADDR_W'(t);
   end

   always_comb begin
      addr_valid  = (state == RUN);
      busy        = (state == RUN);
      done        = (state == FIN);
      addr_out    = '0;
      pad_flag    = 1'b0;
      window_last = 1'b0;
      if (state == RUN) begin
         pad_flag    = !in_range;
         window_last = (ky == kh_max) && (kx == kw_max) && (t == t_max);
         if (in_range) addr_out = base_r + word_idx * ADDR_W'(WORD_BYTES);
      end
   end

endmodule

// File: tb/tb_ifm_window_addr_gen.sv
// Randomised scoreboard bench for ifm_window_addr_gen against a loop-nest reference model.
module tb_ifm_window_addr_gen;

   typedef struct {
      logic [31:0] base;
      int iw, ih, ic, ow, oh, kw, kh, st, pd;
   } cfg_t;

   typedef struct {
      logic [31:0] addr;
      logic        pad;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [7:0]  ifm_w = '0, ifm_h = '0, ifm_c = '0, ofm_w = '0, ofm_h = '0;
   logic [3:0]  kernel_w = '0, kernel_h = '0;
   logic [1:0]  stride = '0, pad = '0;
   logic [31:0] addr_out;
   logic        addr_valid, pad_flag, window_last, busy, done;
   logic        addr_ready = 1'b1;

   int total = 0, bad = 0;
   int cyc = 0, beats = 0, dones = 0, done_cyc = 0, last_hs = 0, start_cyc = 0;
   bit rnd = 0;
   beat_t exp_q[$];
   logic [31:0] obs_addr[$];
   logic        obs_pad[$];

   logic        stalled_prev = 0;
   logic [31:0] held_addr;
   logic        held_pad, held_last;

   ifm_window_addr_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .ifm_w(ifm_w), .ifm_h(ifm_h), .ifm_c(ifm_c), .ofm_w(ofm_w), .ofm_h(ofm_h),
      .kernel_w(kernel_w), .kernel_h(kernel_h), .stride(stride), .pad(pad),
      .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
      .pad_flag(pad_flag), .window_last(window_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      #1 addr_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference: plain loop nest over the output/kernel/tile space
   function automatic int gen_model(input cfg_t c);
      int tiles, s, n;
      beat_t b;
      n = 0;
      if (c.ow == 0 || c.oh == 0 || c.kw == 0 || c.kh == 0 || c.ic == 0) return 0;
      tiles = (c.ic + 15) / 16;
      s = (c.st == 0) ? 1 : c.st;
      for (int oy = 0; oy < c.oh; oy++)
         for (int ox = 0; ox < c.ow; ox++)
            for (int ky = 0; ky < c.kh; ky++)
               for (int kx = 0; kx < c.kw; kx++)
                  for (int t = 0; t < tiles; t++) begin
                     int iy, ix;
                     iy = oy * s + ky - c.pd;
                     ix = ox * s + kx - c.pd;
                     b.pad  = !(iy >= 0 && iy < c.ih && ix >= 0 && ix < c.iw);
                     b.addr = b.pad ? 32'd0 : c.base + 32'(((iy * c.iw + ix) * tiles + t) * 4);
                     b.last = (ky == c.kh - 1) && (kx == c.kw - 1) && (t == tiles - 1);
                     exp_q.push_back(b);
                     n++;
                  end
      return n;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         stalled_prev = 0;
      end else begin
         chk("busy_eq_valid", busy, addr_valid);
         if (stalled_prev) begin
            chk("stall_valid", addr_valid, 1'b1);
            chk("stall_addr", addr_out, held_addr);
            chk("stall_pad", pad_flag, held_pad);
            chk("stall_last", window_last, held_last);
         end
         if (addr_valid && addr_ready) begin
            beats++;
            last_hs = cyc;
            obs_addr.push_back(addr_out);
            obs_pad.push_back(pad_flag);
            if (exp_q.size() == 0) begin
               chk("extra_beat", 1'b1, 1'b0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("addr", addr_out, e.addr);
               chk("pad_flag", pad_flag, e.pad);
               chk("window_last", window_last, e.last);
            end
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
         end
         stalled_prev = addr_valid && !addr_ready;
         held_addr = addr_out;
         held_pad  = pad_flag;
         held_last = window_last;
      end
   end

   task automatic drive_cfg(input cfg_t c);
      base_addr = c.base;
      ifm_w = 8'(c.iw); ifm_h = 8'(c.ih); ifm_c = 8'(c.ic);
      ofm_w = 8'(c.ow); ofm_h = 8'(c.oh);
      kernel_w = 4'(c.kw); kernel_h = 4'(c.kh);
      stride = 2'(c.st); pad = 2'(c.pd);
   endtask

   task automatic run(input cfg_t c, input bit stall, input bit poke);
      int n, d0;
      bit got;
      cfg_t alt;
      exp_q.delete();
      obs_addr.delete();
      obs_pad.delete();
      n = gen_model(c);
      beats = 0;
      d0 = dones;
      rnd = stall;
      @(posedge clk);
      #2 drive_cfg(c);
      start = 1'b1;
      @(posedge clk);
      start_cyc = cyc;
      #2 start = 1'b0;
      got = 0;
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk);
         if (dones != d0) begin
            got = 1;
            break;
         end
         if (poke && i == 5) begin
            alt = c;
            alt.ow = 1; alt.kw = 1; alt.base = 32'h9000;
            #2 drive_cfg(alt);
            start = 1'b1;
            @(posedge clk);
            #2 start = 1'b0;
         end
      end
      chk("done_seen", got, 1'b1);
      chk("queue_drained", exp_q.size(), 0);
      chk("beat_count", beats, n);
      if (n > 0) chk("done_after_last", done_cyc - last_hs, 1);
      else       chk("done_latency_le2", (done_cyc - start_cyc) <= 2, 1'b1);
      repeat (3) @(posedge clk);
      chk("done_single_pulse", dones - d0, 1);
      rnd = 0;
   endtask

   initial begin
      cfg_t c1, c2, c3, c4, cz, cr;
      c1 = '{base: 32'h1000, iw: 4, ih: 4, ic: 16, ow: 2, oh: 2, kw: 3, kh: 3, st: 1, pd: 0};

      #12;
      chk("rst_valid", addr_valid, 1'b0);
      chk("rst_addr", addr_out, 32'h0);
      chk("rst_flags", {pad_flag, window_last, busy, done}, 4'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // basic run with a stray start mid-run
      run(c1, 0, 1);
      chk("t1_b1", obs_addr[0], 32'h1000);
      chk("t1_b2", obs_addr[1], 32'h1004);
      chk("t1_b3", obs_addr[2], 32'h1008);
      chk("t1_b4", obs_addr[3], 32'h1010);
      chk("t1_win2", obs_addr[9], 32'h1004);

      c2 = c1; c2.pd = 1; c2.ow = 4; c2.oh = 4;
      run(c2, 0, 0);
      chk("t2_b1_pad", {obs_pad[0], obs_addr[0]}, {1'b1, 32'h0});
      chk("t2_b5", {obs_pad[4], obs_addr[4]}, {1'b0, 32'h1000});

      c3 = '{base: 32'h2000, iw: 2, ih: 2, ic: 40, ow: 2, oh: 2, kw: 1, kh: 1, st: 1, pd: 0};
      run(c3, 0, 0);
      chk("t3_last_addr", obs_addr[11], 32'h202C);

      c4 = '{base: 32'h3000, iw: 5, ih: 5, ic: 16, ow: 2, oh: 2, kw: 3, kh: 3, st: 2, pd: 0};
      run(c4, 0, 0);
      chk("t4_win2", obs_addr[9], 32'h3008);
      run(c4, 1, 0);

      cz = c1; cz.ow = 0;
      run(cz, 0, 0);

      // reset mid-run
      exp_q.delete();
      void'(gen_model(c2));
      rnd = 1;
      @(posedge clk);
      #2 drive_cfg(c2);
      start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (12) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", addr_valid, 1'b0);
      chk("mid_rst_addr", addr_out, 32'h0);
      chk("mid_rst_flags", {pad_flag, window_last, busy, done}, 4'b0);
      @(posedge clk);
      chk("mid_rst_no_done", done, 1'b0);
      #2 rst_n = 1'b1;
      rnd = 0;
      run(c1, 0, 0);
      chk("restart_b1", obs_addr[0], 32'h1000);

      for (int k = 0; k < 8; k++) begin
         cr.base = {$urandom_range(0, 255), 8'h00};
         cr.iw = $urandom_range(1, 6);
         cr.ih = $urandom_range(1, 6);
         cr.ic = $urandom_range(1, 40);
         cr.ow = $urandom_range(1, 4);
         cr.oh = $urandom_range(1, 3);
         cr.kw = $urandom_range(1, 3);
         cr.kh = $urandom_range(1, 3);
         cr.st = $urandom_range(0, 3);
         cr.pd = $urandom_range(0, 2);
         run(cr, k[0], 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
